// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the round-robin Wishbone arbiter
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_TOUT = 2'd2
   } arb_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Pointer width; never below 1 so a 2-master build still has a real index bit.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin picker starting after the last winner
module wb_rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   int w_c;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_c     = 0;
      for (int k = 1; k <= N; k++) begin
         w_c = int'(i_last) + k;
         if (w_c >= N) w_c = w_c - N;
         if (!o_valid && i_req[IW'(w_c)]) begin
            o_valid          = 1'b1;
            o_gnt[IW'(w_c)]  = 1'b1;
            o_idx            = IW'(w_c);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - N-master to 1-slave Wishbone B3 round-robin arbiter with bus watchdog
module wb_arbiter_rr
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_n_i,
   input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]      wbm_we_i,
   input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
   output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]      wbm_ack_o,
   output logic [NUM_MASTERS-1:0]      wbm_err_o,
   output logic [NUM_MASTERS-1:0]      wbm_rty_o,
   output logic [AW-1:0]               wbs_adr_o,
   output logic [DW-1:0]               wbs_dat_o,
   output logic [DW/8-1:0]             wbs_sel_o,
   output logic                        wbs_we_o,
   output logic                        wbs_cyc_o,
   output logic                        wbs_stb_o,
   output logic [2:0]                  wbs_cti_o,
   output logic [1:0]                  wbs_bte_o,
   input  logic [DW-1:0]               wbs_dat_i,
   input  logic                        wbs_ack_i,
   input  logic                        wbs_err_i,
   input  logic                        wbs_rty_i,
   output logic [NUM_MASTERS-1:0]      grant_o,
   output logic                        timeout_o
);

   localparam int          IW         = idx_width(NUM_MASTERS);
   localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
   localparam int          SW         = DW / 8;

   arb_state_e             r_state;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [IW-1:0]          r_gidx;
   logic [IW-1:0]          r_last;
   logic [15:0]            r_wdog;

   logic [NUM_MASTERS-1:0] w_pick_gnt;
   logic [IW-1:0]          w_pick_idx;
   logic                   w_pick_valid;
   logic                   w_busy;
   logic                   w_tout;
   logic                   w_g_cyc;
   logic                   w_g_stb;
   logic                   w_resp;
   logic                   w_wdog_fire;

   wb_rr_pick #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_pick (
      .i_req   (wbm_cyc_i),
      .i_last  (r_last),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   assign w_busy      = (r_state == ST_BUSY);
   assign w_tout      = (r_state == ST_TOUT);
   assign w_g_cyc     = wbm_cyc_i[r_gidx];
   assign w_g_stb     = wbm_stb_i[r_gidx];
   assign w_resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
   // A response in the firing cycle takes precedence over the watchdog.
   assign w_wdog_fire = (TIMEOUT_CYCLES != 0) && w_g_stb && !w_resp && (r_wdog == WDOG_LIMIT);

   assign wbs_adr_o = wbm_adr_i[r_gidx*AW +: AW];
   assign wbs_dat_o = wbm_dat_i[r_gidx*DW +: DW];
   assign wbs_sel_o = wbm_sel_i[r_gidx*SW +: SW];
   assign wbs_cti_o = wbm_cti_i[r_gidx*3 +: 3];
   assign wbs_bte_o = wbm_bte_i[r_gidx*2 +: 2];
   assign wbs_we_o  = w_busy & wbm_we_i[r_gidx];
   assign wbs_cyc_o = w_busy & w_g_cyc;
   assign wbs_stb_o = w_busy & w_g_stb;

   assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
   assign wbm_ack_o = r_grant & {NUM_MASTERS{w_busy & wbs_ack_i}};
   assign wbm_err_o = r_grant & {NUM_MASTERS{(w_busy & wbs_err_i) | w_tout}};
   assign wbm_rty_o = r_grant & {NUM_MASTERS{w_busy & wbs_rty_i}};
   assign grant_o   = r_grant;
   assign timeout_o = w_tout;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_gidx  <= '0;
         r_last  <= IW'(NUM_MASTERS - 1);
         r_wdog  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wdog <= '0;
               if (w_pick_valid) begin
                  r_grant <= w_pick_gnt;
                  r_gidx  <= w_pick_idx;
                  r_last  <= w_pick_idx;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!w_g_cyc) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_wdog  <= '0;
               end else if (w_wdog_fire) begin
                  r_state <= ST_TOUT;
                  r_wdog  <= '0;
               end else if (w_g_stb && !w_resp) begin
                  r_wdog  <= r_wdog + 16'd1;
               end else begin
                  r_wdog  <= '0;
               end
            end
            ST_TOUT: begin
               r_wdog <= '0;
               if (w_g_cyc) begin
                  r_state <= ST_BUSY;
               end else begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_wdog  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - directed self-checking bench for wb_arbiter_rr (4 masters, watchdog of 4)
module tb_wb_arbiter_rr;
   import wb_arb_pkg::*;

   localparam int NM = 4;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NM*AW-1:0]  m_adr;
   logic [NM*DW-1:0]  m_dat;
   logic [NM*DW/8-1:0] m_sel;
   logic [NM-1:0]     m_we, m_cyc, m_stb;
   logic [NM*3-1:0]   m_cti;
   logic [NM*2-1:0]   m_bte;
   logic [NM*DW-1:0]  m_dat_o;
   logic [NM-1:0]     m_ack, m_err, m_rty;
   logic [AW-1:0]     s_adr;
   logic [DW-1:0]     s_dat_o;
   logic [DW/8-1:0]   s_sel;
   logic              s_we, s_cyc, s_stb;
   logic [2:0]        s_cti;
   logic [1:0]        s_bte;
   logic [DW-1:0]     s_dat_i;
   logic              s_ack, s_err, s_rty;
   logic [NM-1:0]     grant;
   logic              tout;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_arbiter_rr #(
      .NUM_MASTERS    (NM),
      .AW             (AW),
      .DW             (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .wbm_adr_i  (m_adr),
      .wbm_dat_i  (m_dat),
      .wbm_sel_i  (m_sel),
      .wbm_we_i   (m_we),
      .wbm_cyc_i  (m_cyc),
      .wbm_stb_i  (m_stb),
      .wbm_cti_i  (m_cti),
      .wbm_bte_i  (m_bte),
      .wbm_dat_o  (m_dat_o),
      .wbm_ack_o  (m_ack),
      .wbm_err_o  (m_err),
      .wbm_rty_o  (m_rty),
      .wbs_adr_o  (s_adr),
      .wbs_dat_o  (s_dat_o),
      .wbs_sel_o  (s_sel),
      .wbs_we_o   (s_we),
      .wbs_cyc_o  (s_cyc),
      .wbs_stb_o  (s_stb),
      .wbs_cti_o  (s_cti),
      .wbs_bte_o  (s_bte),
      .wbs_dat_i  (s_dat_i),
      .wbs_ack_i  (s_ack),
      .wbs_err_i  (s_err),
      .wbs_rty_i  (s_rty),
      .grant_o    (grant),
      .timeout_o  (tout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [NM-1:0] e_oh;
      int            e;

      m_adr = '0; m_dat = '0; m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0;
      m_cti = '0; m_bte = '0; s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

      step(); step();
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_s_cyc", 64'(s_cyc), 64'h0);
      chk("rst_s_stb", 64'(s_stb), 64'h0);
      chk("rst_s_we",  64'(s_we),  64'h0);
      chk("rst_ack",   64'(m_ack), 64'h0);
      chk("rst_err",   64'(m_err), 64'h0);
      chk("rst_tout",  64'(tout),  64'h0);
      rst_n = 1'b1;

      // two masters request together; master 0 wins first
      m_cyc = 4'b0011; m_stb = 4'b0011; m_we = 4'b0001;
      m_adr[0*AW +: AW] = 16'h1000; m_adr[1*AW +: AW] = 16'h2000;
      m_dat[0*DW +: DW] = 16'hA0A0; m_dat[1*DW +: DW] = 16'hB1B1;
      s_dat_i = 16'hBEEF;
      #1;
      chk("t1_latency_cyc", 64'(s_cyc), 64'h0);
      step();
      chk("t1_grant0", 64'(grant), 64'h1);
      chk("t1_s_cyc",  64'(s_cyc), 64'h1);
      chk("t1_s_adr",  64'(s_adr), 64'h1000);
      chk("t1_s_dat",  64'(s_dat_o), 64'hA0A0);
      chk("t1_s_we",   64'(s_we), 64'h1);
      chk("t1_rdata_bcast", 64'(m_dat_o[1*DW +: DW]), 64'hBEEF);
      s_ack = 1'b1; #1;
      chk("t1_ack0", 64'(m_ack), 64'h1);
      step();
      s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; #1;
      chk("t1_cyc_follow", 64'(s_cyc), 64'h0);
      step();
      chk("t1_idle_bubble", 64'(grant), 64'h0);
      step();
      chk("t1_grant1", 64'(grant), 64'h2);
      chk("t1_s_adr1", 64'(s_adr), 64'h2000);
      chk("t1_s_we1",  64'(s_we), 64'h0);
      s_rty = 1'b1; #1;
      chk("t1_rty1", 64'(m_rty), 64'h2);
      s_rty = 1'b0;
      s_err = 1'b1; #1;
      chk("t1_err1", 64'(m_err), 64'h2);
      s_err = 1'b0;
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      step();
      chk("t1_release", 64'(grant), 64'h0);

      // rotation with all four masters requesting continuously
      rst_n = 1'b0; #1; rst_n = 1'b1;
      m_cyc = 4'b1111; m_stb = 4'b1111; m_we = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         e = k % NM;
         e_oh = NM'(1) << e;
         step();
         chk("rot_grant", 64'(grant), 64'(e_oh));
         s_ack = 1'b1; #1;
         chk("rot_ack", 64'(m_ack), 64'(e_oh));
         step();
         s_ack = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
         step();
         chk("rot_bubble", 64'(grant), 64'h0);
         m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
      end
      m_cyc = '0; m_stb = '0;

      // 8-beat incrementing burst by master 1 while master 0 waits
      m_cyc = 4'b0011; m_stb = 4'b0011;
      m_cti[1*3 +: 3] = CTI_INCR;
      step();
      for (int b = 0; b < 8; b++) begin
         if (b == 7) m_cti[1*3 +: 3] = CTI_EOB;
         s_ack = 1'b1; #1;
         chk("burst_grant", 64'(grant), 64'h2);
         chk("burst_ack",   64'(m_ack), 64'h2);
         chk("burst_cti",   64'(s_cti), (b == 7) ? 64'(CTI_EOB) : 64'(CTI_INCR));
         step();
      end
      s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
      step();
      chk("burst_bubble", 64'(grant), 64'h0);
      step();
      chk("burst_next_m0", 64'(grant), 64'h1);

      // watchdog: slave never responds to master 0
      chk("wd_c1_tout", 64'(tout), 64'h0);
      for (int c = 2; c <= 4; c++) begin
         step();
         chk("wd_stall_tout", 64'(tout), 64'h0);
         chk("wd_stall_err",  64'(m_err), 64'h0);
      end
      step();
      chk("wd_err",   64'(m_err), 64'h1);
      chk("wd_tout",  64'(tout),  64'h1);
      chk("wd_s_cyc", 64'(s_cyc), 64'h0);
      chk("wd_s_stb", 64'(s_stb), 64'h0);
      step();
      chk("wd_after_tout",  64'(tout),  64'h0);
      chk("wd_after_s_cyc", 64'(s_cyc), 64'h1);
      chk("wd_after_err",   64'(m_err), 64'h0);

      // ack on the 4th stalled cycle beats the watchdog
      step(); step(); step();
      s_ack = 1'b1; #1;
      chk("wd_race_ack",  64'(m_ack), 64'h1);
      chk("wd_race_err",  64'(m_err), 64'h0);
      chk("wd_race_tout", 64'(tout),  64'h0);
      step();
      s_ack = 1'b0; #1;
      chk("wd_race_tout2", 64'(tout),  64'h0);
      chk("wd_race_grant", 64'(grant), 64'h1);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      step();

      // asynchronous reset in the middle of a burst
      m_cyc = 4'b0100; m_stb = 4'b0100; m_cti[2*3 +: 3] = CTI_INCR;
      step();
      chk("ar_grant2", 64'(grant), 64'h4);
      s_ack = 1'b1;
      step();
      #3;
      rst_n = 1'b0; #1;
      chk("ar_s_cyc", 64'(s_cyc), 64'h0);
      chk("ar_grant", 64'(grant), 64'h0);
      chk("ar_ack",   64'(m_ack), 64'h0);
      chk("ar_err",   64'(m_err), 64'h0);
      s_ack = 1'b0; m_cyc = 4'b1111; m_stb = 4'b1111;
      #1 rst_n = 1'b1;
      step();
      chk("ar_first_m0", 64'(grant), 64'h1);
      m_cyc = '0; m_stb = '0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Parametrised N-master to 1-slave Wishbone B3 arbiter; successor to the fixed two-master memory arbiter in the generic OR1200 system interconnect.
- Adds round-robin fairness, configurable address/data width and master count, grant held for the whole cycle (bursts included), and a bus-timeout watchdog that returns err to a stalled master.
- Sits in front of shared slaves (memory, peripheral bridge); fed by per-master wb_mux outputs.

Parameters:
- NUM_MASTERS, 2, number of masters; 2..16.
- AW, 32, address width.
- DW, 32, data width; multiple of 8; SEL width is DW/8.
- TIMEOUT_CYCLES, 255, cycles with stb high and no ack/err/rty before the watchdog fires; 0 disables the watchdog; max 65535.

Ports:
- wb_clk_i  in  1  bus clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wbm_adr_i  in  NUM_MASTERS*AW  master addresses; master k in slice k.
- wbm_dat_i  in  NUM_MASTERS*DW  master write data.
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects.
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  per-master control.
- wbm_cti_i  in  NUM_MASTERS*3  cycle type.
- wbm_bte_i  in  NUM_MASTERS*2  burst type.
- wbm_dat_o  out  NUM_MASTERS*DW  read data; wbs_dat_i broadcast to all slices.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  responses; granted master only.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW/DW/DW/8/1/1/1/3/2  slave request.
- wbs_dat_i  in  DW; wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  slave response.
- grant_o  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (wb_rst_n_i low, asynchronous) clears everything: state IDLE, grant_o 0, wbs_cyc_o/wbs_stb_o/wbs_we_o 0, all wbm_ack/err/rty_o 0, timeout_o 0, watchdog counter 0.
- Reset also sets the round-robin pointer last = NUM_MASTERS-1, so master 0 wins first.
- Reset asserted mid-transfer aborts the transfer immediately; no response is issued.
- FSM states: IDLE, BUSY, TOUT.
- IDLE:
  - If any wbm_cyc_i is high, pick the first requester searching last+1, last+2, ... modulo NUM_MASTERS.
  - Register grant, set last = winner, go to BUSY.
  - Latency: wbs_cyc_o rises one cycle after the winning wbm_cyc_i.
- BUSY:
  - Slave request signals are muxed from the granted slice; wbs_cyc_o = granted cyc, wbs_stb_o = granted stb.
  - Slave ack/err/rty are routed combinationally (zero latency) to the granted master only.
  - The grant holds regardless of cti/bte or of other requests; there is no preemption.
  - When the granted wbm_cyc_i goes low, go to IDLE. One mandatory idle cycle follows before the next grant.
- Watchdog (TIMEOUT_CYCLES>0):
  - A 16-bit counter increments each BUSY cycle with granted stb high and no ack/err/rty.
  - It clears on any response, on stb low, and on leaving BUSY.
  - When the counter equals TIMEOUT_CYCLES-1 and no response arrives that cycle, go to TOUT.
- TOUT (exactly one cycle):
  - wbs_cyc_o and wbs_stb_o are forced to 0.
  - wbm_err_o of the granted master is 1; timeout_o is 1.
  - Next state: BUSY if the granted cyc is still high, else IDLE. Counter is 0 on re-entry.
- A slave response arriving in the same cycle the watchdog would fire wins: no timeout.
- Requests arriving in the same cycle as a release are arbitrated in the following IDLE cycle. A single continuous requester re-wins after the idle bubble.
- Responses to a master whose stb is low are still forwarded; the slave is responsible for protocol compliance.

Decomposition:
- Package wb_arb_pkg: state encoding (IDLE/BUSY/TOUT), CTI/BTE constants, clog2 helper for the pointer width.
- Sub-module wb_rr_pick: combinational round-robin picker. Inputs are the request vector and the last pointer; outputs are a one-hot winner and its index. Reusable by future multi-slave crossbars.

Test Plan:
- Reset, then wbm_cyc_i=2'b11 from cycle 0 (NUM_MASTERS=2) -> grant_o=2'b01 at cycle 1; after m0 drops cyc, one idle cycle, then grant_o=2'b10.
- NUM_MASTERS=4, all masters issue back-to-back single transfers -> grants rotate 0,1,2,3,0 and no master is granted twice in a row while others wait.
- m1 runs an 8-beat incrementing burst (cti=3'b010, final 3'b111) while m0 requests -> grant_o stays 2'b10 through all 8 acks; m0 is granted after the idle cycle.
- TIMEOUT_CYCLES=4, slave never acks -> err to the granted master exactly 4 cycles after stb rises; timeout_o pulses once; wbs_cyc_o is 0 that cycle.
- TIMEOUT_CYCLES=4, ack on the 4th stalled cycle -> ack delivered, no err, timeout_o stays 0.
- Drive wb_rst_n_i low mid-burst, asynchronously between clock edges -> wbs_cyc_o, grant_o and all responses go to 0 without waiting for a clock edge; after reset, master 0 wins first.
